// File: rtl/rom_fetch_pkg.sv
// Shared types and widths for the EPROM word fetcher.
`timescale 1ns/1ps
package rom_fetch_pkg;

    localparam int unsigned ROM_ADDR_W = 20;
    localparam int unsigned ROM_DATA_W = 8;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned WAIT_CTR_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_t;

endpackage

// File: rtl/rom_wait_ctr.sv
// Loadable down-counter timing the output-enable window of one EPROM byte read.
`timescale 1ns/1ps
module rom_wait_ctr
    import rom_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  dec,
    input  logic [WAIT_CTR_W-1:0] load_val,
    output logic                  done
);

    logic [WAIT_CTR_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WAIT_CTR_W'(1);
        end
    end

    // High during the final cycle of the window, i.e. the cycle whose closing edge samples data.
    assign done = (count_q == WAIT_CTR_W'(1));

endmodule

// File: rtl/rom_fetch.sv
// Fetches a little-endian 16-bit word from an 8-bit EPROM as two timed byte reads.
`timescale 1ns/1ps
module rom_fetch
    import rom_fetch_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ROM_ADDR_W-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_W-1:0]     rsp_data,
    output logic                  _rom_cs,
    output logic                  _rom_oe,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [ROM_DATA_W-1:0] rom_data
);

    localparam logic [WAIT_CTR_W-1:0] WaitLoad = WAIT_CTR_W'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic                    byte_idx_q, byte_idx_d;
    logic                    rom_cs_n_q, rom_cs_n_d;
    logic                    rom_oe_n_q, rom_oe_n_d;
    logic [ROM_ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [WORD_W-1:0]       rsp_data_q, rsp_data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    ctr_load, ctr_dec, ctr_done;

    rom_wait_ctr u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .dec      (ctr_dec),
        .load_val (WaitLoad),
        .done     (ctr_done)
    );

    assign req_ready = (state_q == StIdle) && !rst;

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        rom_cs_n_d  = rom_cs_n_q;
        rom_oe_n_d  = rom_oe_n_q;
        rom_addr_d  = rom_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        ctr_load    = 1'b0;
        ctr_dec     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    rom_addr_d = req_addr;
                    rom_cs_n_d = 1'b0;
                    rom_oe_n_d = 1'b1;
                    byte_idx_d = 1'b0;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                // Address has settled for a cycle with the chip selected; open the output now.
                rom_oe_n_d = 1'b0;
                ctr_load   = 1'b1;
                state_d    = StAccess;
            end
            StAccess: begin
                ctr_dec = 1'b1;
                if (ctr_done) begin
                    rom_oe_n_d = 1'b1;
                    if (!byte_idx_q) begin
                        rsp_data_d[7:0] = rom_data;
                        rom_addr_d      = rom_addr_q + ROM_ADDR_W'(1);
                        byte_idx_d      = 1'b1;
                        state_d         = StSetup;
                    end else begin
                        rsp_data_d[15:8] = rom_data;
                        rom_cs_n_d       = 1'b1;
                        rsp_valid_d      = 1'b1;
                        state_d          = StResp;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            byte_idx_q  <= 1'b0;
            rom_cs_n_q  <= 1'b1;
            rom_oe_n_q  <= 1'b1;
            rom_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            rom_cs_n_q  <= rom_cs_n_d;
            rom_oe_n_q  <= rom_oe_n_d;
            rom_addr_q  <= rom_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign _rom_cs   = rom_cs_n_q;
    assign _rom_oe   = rom_oe_n_q;
    assign rom_addr  = rom_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_rom_fetch.sv
// Self-checking bench for rom_fetch: table of single fetches, backpressure, reset and back-to-back.
`timescale 1ns/1ps
module tb_rom_fetch;

    localparam int W_A = 3;
    localparam int W_B = 1;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [19:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_data  [2];
    logic        rom_cs_n  [2];
    logic        rom_oe_n  [2];
    logic [19:0] rom_addr  [2];
    logic [7:0]  rom_data  [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pops     = 0;

    typedef struct {
        int          inst;
        logic [15:0] word;
        int          acc_cyc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [19:0] addr;
        logic [15:0] exp;
        int          stall;
    } vec_t;
    vec_t vecs[5];

    logic        prev_valid  [2];
    logic        prev_oe_low [2];
    logic [19:0] prev_addr   [2];

    function automatic logic [7:0] rom_byte(input logic [19:0] a);
        case (a)
            20'h00010: return 8'h34;
            20'h00011: return 8'h12;
            20'hFFFFF: return 8'hCD;
            20'h00000: return 8'hAB;
            default:   return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h9};
        endcase
    endfunction

    function automatic logic [15:0] word_model(input logic [19:0] a);
        logic [19:0] n;
        n = a + 20'd1;
        return {rom_byte(n), rom_byte(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // EPROM model drives a marker value whenever the output is disabled.
    assign rom_data[0] = rom_oe_n[0] ? 8'hEE : rom_byte(rom_addr[0]);
    assign rom_data[1] = rom_oe_n[1] ? 8'hEE : rom_byte(rom_addr[1]);

    rom_fetch #(.WAIT_CYCLES(W_A)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_addr  (req_addr[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_data  (rsp_data[0]),
        ._rom_cs   (rom_cs_n[0]),
        ._rom_oe   (rom_oe_n[0]),
        .rom_addr  (rom_addr[0]),
        .rom_data  (rom_data[0])
    );

    rom_fetch #(.WAIT_CYCLES(W_B)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_addr  (req_addr[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_data  (rsp_data[1]),
        ._rom_cs   (rom_cs_n[1]),
        ._rom_oe   (rom_oe_n[1]),
        .rom_addr  (rom_addr[1]),
        .rom_data  (rom_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int k = 0; k < 2; k++) begin
                prev_valid[k]  <= 1'b0;
                prev_oe_low[k] <= 1'b0;
                prev_addr[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!rom_oe_n[k]) begin
                    chk("oe_implies_cs", {31'b0, rom_cs_n[k]}, 32'd0);
                    if (prev_oe_low[k]) chk("addr_stable_oe", {12'b0, rom_addr[k]},
                                            {12'b0, prev_addr[k]});
                end
                prev_oe_low[k] <= !rom_oe_n[k];
                prev_addr[k]   <= rom_addr[k];

                if (req_valid[k] && req_ready[k]) begin
                    exp_t e;
                    e.inst    = k;
                    e.word    = word_model(req_addr[k]);
                    e.acc_cyc = cyc + 1;
                    exp_q.push_back(e);
                end

                if (rsp_valid[k]) begin
                    logic have;
                    chk("rsp_blocks_req", {31'b0, req_ready[k]}, 32'd0);
                    have = (exp_q.size() != 0) && (exp_q[0].inst == k);
                    chk("rsp_expected", {31'b0, have}, 32'd1);
                    if (have) begin
                        if (!prev_valid[k]) chk("latency", cyc - exp_q[0].acc_cyc,
                                                (k == 0) ? 2 * W_A + 2 : 2 * W_B + 2);
                        if (rsp_ready[k]) begin
                            chk("sb_data", {16'b0, rsp_data[k]}, {16'b0, exp_q[0].word});
                            void'(exp_q.pop_front());
                            pops <= pops + 1;
                        end
                    end
                end
                prev_valid[k] <= rsp_valid[k];
            end
        end
    end

    task automatic fetch_a(input logic [19:0] addr, input int stall, input logic [15:0] exp,
                           output logic [15:0] word, output logic [19:0] a1,
                           output logic [19:0] a2);
        logic ok;
        logic seen;
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        req_addr[0]  = addr;
        rsp_ready[0] = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[0]) begin ok = 1'b1; break; end
        end
        chk("accept", {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_addr[0]  = 20'h5A5A5;
        a1 = '0; a2 = '0; seen = 1'b0; ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!rom_oe_n[0]) begin
                if (!seen) begin a1 = rom_addr[0]; seen = 1'b1; end
                else if (rom_addr[0] != a1) a2 = rom_addr[0];
            end
            if (rsp_valid[0]) begin ok = 1'b1; break; end
        end
        chk("rsp_arrives", {31'b0, ok}, 32'd1);
        word = rsp_data[0];
        for (int i = 0; i < stall; i++) begin
            chk("hold_valid", {31'b0, rsp_valid[0]}, 32'd1);
            chk("hold_data", {16'b0, rsp_data[0]}, {16'b0, exp});
            chk("hold_req_ready", {31'b0, req_ready[0]}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("take_req_ready", {31'b0, req_ready[0]}, 32'd0);
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        chk("after_take_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("after_take_ready", {31'b0, req_ready[0]}, 32'd1);
    endtask

    initial begin
        logic [15:0] word;
        logic [19:0] a1, a2, nxt;
        logic        ok, any;
        int          acc1, acc2, base;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_addr[k]  = '0;
            rsp_ready[k] = 1'b0;
        end

        vecs[0] = '{addr: 20'h00010, exp: 16'h1234, stall: 0};
        vecs[1] = '{addr: 20'hFFFFF, exp: 16'hABCD, stall: 1};
        vecs[2] = '{addr: 20'h12345, exp: word_model(20'h12345), stall: 2};
        vecs[3] = '{addr: 20'h7FFFF, exp: word_model(20'h7FFFF), stall: 0};
        vecs[4] = '{addr: 20'hABCDE, exp: word_model(20'hABCDE), stall: 3};

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", {31'b0, req_ready[k]}, 32'd0);
            chk("rst_cs", {31'b0, rom_cs_n[k]}, 32'd1);
            chk("rst_oe", {31'b0, rom_oe_n[k]}, 32'd1);
            chk("rst_addr", {12'b0, rom_addr[k]}, 32'd0);
            chk("rst_valid", {31'b0, rsp_valid[k]}, 32'd0);
            chk("rst_data", {16'b0, rsp_data[k]}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'b0, req_ready[0]}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            fetch_a(vecs[i].addr, vecs[i].stall, vecs[i].exp, word, a1, a2);
            nxt = vecs[i].addr + 20'd1;
            chk("vec_word", {16'b0, word}, {16'b0, vecs[i].exp});
            chk("vec_addr_lo", {12'b0, a1}, {12'b0, vecs[i].addr});
            chk("vec_addr_hi", {12'b0, a2}, {12'b0, nxt});
        end

        // Backpressure: five stalled cycles on a known word.
        fetch_a(20'h00010, 5, 16'h1234, word, a1, a2);
        chk("bp_word", {16'b0, word}, 32'h1234);

        // Reset while the high byte is being read.
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        req_addr[0]  = 20'h00010;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[0]) begin ok = 1'b1; break; end
        end
        chk("rst_test_accept", {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!rom_oe_n[0] && rom_addr[0] == 20'h00011) begin ok = 1'b1; break; end
        end
        chk("reach_hi_access", {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_cs", {31'b0, rom_cs_n[0]}, 32'd1);
        chk("midrst_oe", {31'b0, rom_oe_n[0]}, 32'd1);
        chk("midrst_valid", {31'b0, rsp_valid[0]}, 32'd0);
        any = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid[0]) any = 1'b1;
        end
        chk("no_rsp_after_rst", {31'b0, any}, 32'd0);
        fetch_a(20'h00010, 0, 16'h1234, word, a1, a2);
        chk("post_rst_word", {16'b0, word}, 32'h1234);

        // Back-to-back on the single-wait instance with req_valid held high.
        base = pops;
        @(posedge clk); #1;
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1;
        req_addr[1]  = 20'h00000;
        ok = 1'b0;
        acc1 = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[1]) begin ok = 1'b1; acc1 = cyc + 1; break; end
        end
        chk("b2b_accept1", {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        req_addr[1] = 20'h00002;
        ok = 1'b0;
        acc2 = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (req_ready[1]) begin ok = 1'b1; acc2 = cyc + 1; break; end
        end
        chk("b2b_accept2", {31'b0, ok}, 32'd1);
        chk("b2b_gap", acc2 - acc1, 32'd6);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (pops >= base + 2) begin ok = 1'b1; break; end
        end
        chk("b2b_two_rsps", {31'b0, ok}, 32'd1);
        chk("b2b_last_word", {16'b0, rsp_data[1]}, {16'b0, word_model(20'h00002)});
        rsp_ready[1] = 1'b0;

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
